// File: rtl/rv_load_store_unit.sv
// RV32I load/store unit: turns decoder memory controls into a single
// request/acknowledge word-bus access with byte-lane steering, store-data
// replication, load sign/zero extension, alignment checking and a bus
// timeout. Reports each access with a one-cycle done pulse qualified by err.
module rv_load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        data_r,
   input  logic        data_w,
   input  logic [1:0]  data_size,
   input  logic        unsigned_value,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rd_data
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             err_reg, err_next;

   logic             we_reg;
   logic [31:0]      addr_reg;
   logic [3:0]       be_reg;
   logic [31:0]      wdata_reg;
   logic [31:0]      rd_data_reg;
   logic [1:0]       size_reg;
   logic [1:0]       off_reg;
   logic             uns_reg;

   logic             req_seen;
   logic             bad_req;
   logic             misaligned;
   logic [3:0]       be_calc;
   logic [31:0]      wdata_calc;
   logic [7:0]       lane_byte;
   logic [15:0]      lane_half;
   logic [31:0]      load_ext;

   // A start only counts in IDLE and when it names a load or a store.
   assign req_seen = (state_reg == IDLE) && start && (data_r || data_w);

   // Request validity: conflict, illegal size or misalignment all fail early.
   always_comb begin
      misaligned = 1'b0;
      if (data_size == 2'b01) misaligned = addr[0];
      else if (data_size == 2'b10) misaligned = (addr[1:0] != 2'b00);
      bad_req = (data_r && data_w) || (data_size == 2'b11) || misaligned;
   end

   // Byte-enable and store-data steering from the incoming request.
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = store_data;
      case (data_size)
         2'b00: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << addr[1:0];
            wdata_calc = {2{store_data[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = store_data;
         end
      endcase
   end

   // Load lane selection and extension from the latched offset and size.
   always_comb begin
      case (off_reg)
         2'b00:   lane_byte = bus_rdata[7:0];
         2'b01:   lane_byte = bus_rdata[15:8];
         2'b10:   lane_byte = bus_rdata[23:16];
         default: lane_byte = bus_rdata[31:24];
      endcase
      lane_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (size_reg)
         2'b00:   load_ext = uns_reg ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
         2'b01:   load_ext = uns_reg ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
         default: load_ext = bus_rdata;
      endcase
   end

   // Next-state, timeout counter and error flag.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (req_seen) begin
               cnt_next = '0;
               if (bad_req) begin
                  state_next = RESP;
                  err_next   = 1'b1;
               end else begin
                  state_next = BUS;
                  err_next   = 1'b0;
               end
            end
         end
         BUS: begin
            // An ack on the final allowed cycle still counts as success.
            if (bus_ack) begin
               state_next = RESP;
               err_next   = 1'b0;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_next = RESP;
               err_next   = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   // Bus-side latches on accepted start; load result capture on ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_reg      <= 1'b0;
         addr_reg    <= '0;
         be_reg      <= '0;
         wdata_reg   <= '0;
         rd_data_reg <= '0;
         size_reg    <= '0;
         off_reg     <= '0;
         uns_reg     <= 1'b0;
      end else begin
         if (req_seen && !bad_req) begin
            we_reg    <= data_w;
            addr_reg  <= {addr[31:2], 2'b00};
            be_reg    <= be_calc;
            wdata_reg <= wdata_calc;
            size_reg  <= data_size;
            off_reg   <= addr[1:0];
            uns_reg   <= unsigned_value;
         end
         if (state_reg == BUS && bus_ack && !we_reg) begin
            rd_data_reg <= load_ext;
         end
      end
   end

   assign bus_req   = (state_reg == BUS);
   assign bus_we    = we_reg;
   assign bus_addr  = addr_reg;
   assign bus_be    = be_reg;
   assign bus_wdata = wdata_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == RESP);
   assign err       = done && err_reg;
   assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_rv_load_store_unit.sv
// Directed bench for rv_load_store_unit: loads, stores, error paths,
// timeout boundary, ignored starts and asynchronous reset mid-access.
module tb_rv_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        data_r = 1'b0;
   logic        data_w = 1'b0;
   logic [1:0]  data_size = 2'b00;
   logic        unsigned_value = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = '0;
   logic        bus_ack = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rd_data;

   int checks = 0;
   int errors = 0;
   int req_cycles;
   int done_cnt;
   logic done_seen;

   rv_load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_r(data_r), .data_w(data_w),
      .data_size(data_size), .unsigned_value(unsigned_value), .addr(addr),
      .store_data(store_data), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .done(done),
      .err(err), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-16s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Issue a one-cycle start; called and returns on a falling edge.
   task automatic start_op(input logic r, input logic w, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] sd);
      start = 1'b1; data_r = r; data_w = w; data_size = sz;
      unsigned_value = uns; addr = a; store_data = sd;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Acknowledge for one cycle with the given read data.
   task automatic ack_once(input logic [31:0] rdata);
      bus_ack = 1'b1; bus_rdata = rdata;
      @(negedge clk);
      bus_ack = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_req", {31'h0, bus_req}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_be", {28'h0, bus_be}, 32'h0);
      check("rst_rd", rd_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // LB at 0x103, ack on second bus cycle
      start_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
      check("lb_req", {31'h0, bus_req}, 32'h1);
      check("lb_busy", {31'h0, busy}, 32'h1);
      check("lb_addr", bus_addr, 32'h100);
      check("lb_be", {28'h0, bus_be}, 32'h8);
      check("lb_we", {31'h0, bus_we}, 32'h0);
      @(negedge clk);
      check("lb_done_early", {31'h0, done}, 32'h0);
      ack_once(32'h80AABBCC);
      check("lb_done", {31'h0, done}, 32'h1);
      check("lb_err", {31'h0, err}, 32'h0);
      check("lb_rd", rd_data, 32'hFFFFFF80);
      check("lb_req_drop", {31'h0, bus_req}, 32'h0);
      @(negedge clk);
      check("lb_done_1cyc", {31'h0, done}, 32'h0);
      check("lb_idle", {31'h0, busy}, 32'h0);

      // LBU at 0x103
      start_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
      @(negedge clk);
      ack_once(32'h80AABBCC);
      check("lbu_rd", rd_data, 32'h00000080);
      @(negedge clk);

      // SH at 0x202, immediate ack
      start_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD);
      check("sh_we", {31'h0, bus_we}, 32'h1);
      check("sh_be", {28'h0, bus_be}, 32'hC);
      check("sh_wdata", bus_wdata, 32'hABCDABCD);
      check("sh_addr", bus_addr, 32'h200);
      ack_once(32'hFFFFFFFF);
      check("sh_done", {31'h0, done}, 32'h1);
      check("sh_err", {31'h0, err}, 32'h0);
      check("sh_rd_hold", rd_data, 32'h00000080);
      @(negedge clk);

      // SB at 0x001 replicates the low byte
      start_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h123456A5);
      check("sb_be", {28'h0, bus_be}, 32'h2);
      check("sb_wdata", bus_wdata, 32'hA5A5A5A5);
      ack_once(32'h0);
      @(negedge clk);

      // Error paths: misaligned word, illegal size, conflict
      start_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h006, 32'h0);
      check("mis_done", {31'h0, done}, 32'h1);
      check("mis_err", {31'h0, err}, 32'h1);
      check("mis_req", {31'h0, bus_req}, 32'h0);
      @(negedge clk);
      check("mis_done_1cyc", {31'h0, done}, 32'h0);
      start_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h000, 32'h0);
      check("ill_done", {31'h0, done}, 32'h1);
      check("ill_err", {31'h0, err}, 32'h1);
      check("ill_req", {31'h0, bus_req}, 32'h0);
      @(negedge clk);
      start_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h000, 32'h0);
      check("cfl_done", {31'h0, done}, 32'h1);
      check("cfl_err", {31'h0, err}, 32'h1);
      check("cfl_req", {31'h0, bus_req}, 32'h0);
      @(negedge clk);

      // LH at 0x40 with no ack: timeout after 16 request cycles
      start_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h040, 32'h0);
      check("to_be", {28'h0, bus_be}, 32'h3);
      req_cycles = 0;
      done_seen = 1'b0;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         if (bus_req) req_cycles++;
         if (done) begin
            done_seen = 1'b1;
            check("to_err", {31'h0, err}, 32'h1);
            check("to_rd_hold", rd_data, 32'h00000080);
            check("to_req_low", {31'h0, bus_req}, 32'h0);
         end else begin
            @(negedge clk);
         end
      end
      check("to_done_seen", {31'h0, done_seen}, 32'h1);
      check("to_req_cycles", req_cycles, 32'd16);
      @(negedge clk);

      // LHU at 0x42, ack on the 16th request cycle wins
      start_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h042, 32'h0);
      repeat (15) @(negedge clk);
      check("edge_req", {31'h0, bus_req}, 32'h1);
      ack_once(32'h80010000);
      check("edge_done", {31'h0, done}, 32'h1);
      check("edge_err", {31'h0, err}, 32'h0);
      check("edge_rd", rd_data, 32'h00008001);
      @(negedge clk);

      // Second start during BUS is ignored
      start_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h020, 32'h0);
      start_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h044, 32'h55555555);
      check("dbl_addr", bus_addr, 32'h020);
      check("dbl_we", {31'h0, bus_we}, 32'h0);
      check("dbl_be", {28'h0, bus_be}, 32'h3);
      done_cnt = 0;
      bus_ack = 1'b1; bus_rdata = 32'h1122F344;
      @(negedge clk);
      bus_ack = 1'b0;
      check("dbl_rd", rd_data, 32'hFFFFF344);
      for (int i = 0; i < 5; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check("dbl_done_cnt", done_cnt, 32'd1);

      // Start with neither load nor store: ignored
      start_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0);
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (done || busy) done_cnt++;
         @(negedge clk);
      end
      check("nop_ignored", done_cnt, 32'd0);

      // Asynchronous reset one cycle into BUS
      start_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
      check("ar_req_pre", {31'h0, bus_req}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_req_async", {31'h0, bus_req}, 32'h0);
      check("ar_busy", {31'h0, busy}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check("ar_no_done", done_cnt, 32'd0);
      start_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
      check("lw_addr", bus_addr, 32'h010);
      check("lw_be", {28'h0, bus_be}, 32'hF);
      ack_once(32'hDEADBEEF);
      check("lw_done", {31'h0, done}, 32'h1);
      check("lw_err", {31'h0, err}, 32'h0);
      check("lw_rd", rd_data, 32'hDEADBEEF);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
